rom_download_sdram_writer: RTL and testbench

- Upstream feeder of the two-port SDRAM controller.
- Converts the byte-wide ioctl ROM download stream into 16-bit word writes on the controller's toggle-handshake ports: port1 (banks 0,1: CPU ROMs) and port2 (banks 2,3: graphics ROMs).
- Backpressures the host with ioctl_wait.
- Flags load completion to the rest of the core.

---
 rtl/rom_download_sdram_writer_if.sv | 44 ++++
 rtl/rom_download_sdram_writer.sv | 236 +++++++++++++++++++++++
 tb/tb_rom_download_sdram_writer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_download_sdram_writer_if.sv
// Bundle of the ioctl download stream and the two SDRAM controller write ports.
// master: the download writer; slave: the host/controller side.
interface rom_download_sdram_writer_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    logic        port1_req;
    logic        port1_ack;
    logic        port1_we;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;

    logic        port2_req;
    logic        port2_ack;
    logic        port2_we;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;

    logic        rom_loaded;

    modport master (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  port1_ack, port2_ack,
        output ioctl_wait,
        output port1_req, port1_we, port1_a, port1_ds, port1_d,
        output port2_req, port2_we, port2_a, port2_ds, port2_d,
        output rom_loaded
    );

    modport slave (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output port1_ack, port2_ack,
        input  ioctl_wait,
        input  port1_req, port1_we, port1_a, port1_ds, port1_d,
        input  port2_req, port2_we, port2_a, port2_ds, port2_d,
        input  rom_loaded
    );
endinterface

// File: rtl/rom_download_sdram_writer.sv
// Packs the byte-wide ioctl ROM download into 16-bit toggle-handshake writes
// on the SDRAM controller's CPU (port1) and graphics (port2) ports.
//
// state    | meaning
// IDLE     | no pending byte (a byte in the holding register is replayed here)
// HALF     | low byte held with its word address, waiting for its partner
// WAIT_ACK | one request outstanding on port1 or port2
// FLUSH    | last lone byte of the download issued, waiting for its ack
// DONE     | download fully written, rom_loaded high
module rom_download_sdram_writer #(
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter logic [24:0] PORT2_BASE = 25'h0100000
) (
    input logic                          clk,
    input logic                          reset,
    rom_download_sdram_writer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALF,
        S_WAIT_ACK,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [23:0] held_w_q, held_w_d;
    logic        hold_vld_q, hold_vld_d;
    logic [24:0] hold_addr_q, hold_addr_d;
    logic [7:0]  hold_byte_q, hold_byte_d;
    logic        p1_req_q, p1_req_d;
    logic [22:0] p1_a_q, p1_a_d;
    logic [1:0]  p1_ds_q, p1_ds_d;
    logic [15:0] p1_d_q, p1_d_d;
    logic        p2_req_q, p2_req_d;
    logic [22:0] p2_a_q, p2_a_d;
    logic [1:0]  p2_ds_q, p2_ds_d;
    logic [15:0] p2_d_q, p2_d_d;
    logic        busy_p2_q, busy_p2_d;
    logic        rom_loaded_q, rom_loaded_d;
    logic        active_q, active_d;
    logic        dl_prev_q, dl_prev_d;

    logic        wait_c;
    logic        index_ok;
    logic        accept;
    logic        use_hold;
    logic        in_vld;
    logic [24:0] in_addr;
    logic [7:0]  in_byte;
    logic        ack_done;
    logic        issue;
    logic [24:0] iss_addr;
    logic [1:0]  iss_ds;
    logic [15:0] iss_d;

    assign wait_c   = (state_q == S_WAIT_ACK) || (state_q == S_FLUSH) || hold_vld_q;
    assign index_ok = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
    assign accept   = index_ok && bus.ioctl_wr && !wait_c;
    assign use_hold = (state_q == S_IDLE) && hold_vld_q;
    assign in_vld   = use_hold || accept;
    assign in_addr  = use_hold ? hold_addr_q : bus.ioctl_addr;
    assign in_byte  = use_hold ? hold_byte_q : bus.ioctl_dout;

    // Only the port that issued the outstanding request is watched for its ack.
    assign ack_done = busy_p2_q ? (bus.port2_ack == p2_req_q) : (bus.port1_ack == p1_req_q);

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        held_w_d     = held_w_q;
        hold_vld_d   = hold_vld_q;
        hold_addr_d  = hold_addr_q;
        hold_byte_d  = hold_byte_q;
        p1_req_d     = p1_req_q;
        p1_a_d       = p1_a_q;
        p1_ds_d      = p1_ds_q;
        p1_d_d       = p1_d_q;
        p2_req_d     = p2_req_q;
        p2_a_d       = p2_a_q;
        p2_ds_d      = p2_ds_q;
        p2_d_d       = p2_d_q;
        busy_p2_d    = busy_p2_q;
        rom_loaded_d = rom_loaded_q;
        active_d     = active_q | index_ok;
        dl_prev_d    = bus.ioctl_download;
        issue        = 1'b0;
        iss_addr     = in_addr;
        iss_ds       = 2'b00;
        iss_d        = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (in_vld) begin
                    hold_vld_d = 1'b0;
                    if (!in_addr[0]) begin
                        lo_d     = in_byte;
                        held_w_d = in_addr[24:1];
                        state_d  = S_HALF;
                    end else begin
                        issue   = 1'b1;
                        iss_ds  = 2'b10;
                        iss_d   = {in_byte, 8'h00};
                        state_d = S_WAIT_ACK;
                    end
                end else if (active_q && !bus.ioctl_download) begin
                    rom_loaded_d = 1'b1;
                    active_d     = 1'b0;
                    state_d      = S_DONE;
                end
            end
            S_HALF: begin
                if (!bus.ioctl_download) begin
                    issue    = 1'b1;
                    iss_addr = {held_w_q, 1'b0};
                    iss_ds   = 2'b01;
                    iss_d    = {8'h00, lo_q};
                    state_d  = S_FLUSH;
                end else if (accept) begin
                    issue = 1'b1;
                    if (bus.ioctl_addr[0] && (bus.ioctl_addr[24:1] == held_w_q)) begin
                        iss_addr = bus.ioctl_addr;
                        iss_ds   = 2'b11;
                        iss_d    = {bus.ioctl_dout, lo_q};
                    end else begin
                        // The lone low byte goes out first; the newcomer waits
                        // in the holding register and is replayed from IDLE.
                        iss_addr    = {held_w_q, 1'b0};
                        iss_ds      = 2'b01;
                        iss_d       = {8'h00, lo_q};
                        hold_vld_d  = 1'b1;
                        hold_addr_d = bus.ioctl_addr;
                        hold_byte_d = bus.ioctl_dout;
                    end
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (ack_done) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (ack_done) begin
                    rom_loaded_d = 1'b1;
                    active_d     = 1'b0;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (index_ok && !dl_prev_q) begin
                    rom_loaded_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            if (iss_addr >= PORT2_BASE) begin
                p2_req_d  = ~p2_req_q;
                p2_a_d    = 23'((iss_addr - PORT2_BASE) >> 1);
                p2_ds_d   = iss_ds;
                p2_d_d    = iss_d;
                busy_p2_d = 1'b1;
            end else begin
                p1_req_d  = ~p1_req_q;
                p1_a_d    = 23'(iss_addr >> 1);
                p1_ds_d   = iss_ds;
                p1_d_d    = iss_d;
                busy_p2_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lo_q         <= 8'h00;
            held_w_q     <= 24'h000000;
            hold_vld_q   <= 1'b0;
            hold_addr_q  <= 25'h0000000;
            hold_byte_q  <= 8'h00;
            // Matching req to ack abandons anything in flight without a new request.
            p1_req_q     <= bus.port1_ack;
            p1_a_q       <= 23'h000000;
            p1_ds_q      <= 2'b00;
            p1_d_q       <= 16'h0000;
            p2_req_q     <= bus.port2_ack;
            p2_a_q       <= 23'h000000;
            p2_ds_q      <= 2'b00;
            p2_d_q       <= 16'h0000;
            busy_p2_q    <= 1'b0;
            rom_loaded_q <= 1'b0;
            active_q     <= 1'b0;
            dl_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            held_w_q     <= held_w_d;
            hold_vld_q   <= hold_vld_d;
            hold_addr_q  <= hold_addr_d;
            hold_byte_q  <= hold_byte_d;
            p1_req_q     <= p1_req_d;
            p1_a_q       <= p1_a_d;
            p1_ds_q      <= p1_ds_d;
            p1_d_q       <= p1_d_d;
            p2_req_q     <= p2_req_d;
            p2_a_q       <= p2_a_d;
            p2_ds_q      <= p2_ds_d;
            p2_d_q       <= p2_d_d;
            busy_p2_q    <= busy_p2_d;
            rom_loaded_q <= rom_loaded_d;
            active_q     <= active_d;
            dl_prev_q    <= dl_prev_d;
        end
    end

    assign bus.ioctl_wait = wait_c;
    assign bus.port1_req  = p1_req_q;
    assign bus.port1_we   = 1'b1;
    assign bus.port1_a    = p1_a_q;
    assign bus.port1_ds   = p1_ds_q;
    assign bus.port1_d    = p1_d_q;
    assign bus.port2_req  = p2_req_q;
    assign bus.port2_we   = 1'b1;
    assign bus.port2_a    = p2_a_q;
    assign bus.port2_ds   = p2_ds_q;
    assign bus.port2_d    = p2_d_q;
    assign bus.rom_loaded = rom_loaded_q;

endmodule

// File: tb/tb_rom_download_sdram_writer.sv
// Directed bench for rom_download_sdram_writer with a 6-cycle-ack controller model.
module tb_rom_download_sdram_writer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rom_download_sdram_writer_if bus ();

    rom_download_sdram_writer #(
        .ROM_INDEX  (8'd0),
        .PORT2_BASE (25'h0100000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Controller model: ack follows req six negedges after the toggle.
    logic ack1_r = 1'b0;
    logic ack2_r = 1'b0;
    logic ack_en = 1'b1;
    int   c1 = 0;
    int   c2 = 0;
    assign bus.port1_ack = ack1_r;
    assign bus.port2_ack = ack2_r;

    always @(negedge clk) begin
        if (!reset && ack_en && bus.port1_req !== ack1_r) begin
            c1++;
            if (c1 >= 6) begin
                ack1_r = bus.port1_req;
                c1 = 0;
            end
        end else c1 = 0;
        if (!reset && ack_en && bus.port2_req !== ack2_r) begin
            c2++;
            if (c2 >= 6) begin
                ack2_r = bus.port2_req;
                c2 = 0;
            end
        end else c2 = 0;
    end

    // Transaction capture {a, ds, d} on each req toggle, plus wait-vs-outstanding monitor.
    logic [40:0] q1[$];
    logic [40:0] q2[$];
    logic p1_prev = 1'b0;
    logic p2_prev = 1'b0;
    logic mon_en = 1'b0;
    int   wait_err = 0;

    always @(posedge clk) begin
        #1;
        if (bus.port1_req !== p1_prev) begin
            q1.push_back({bus.port1_a, bus.port1_ds, bus.port1_d});
            p1_prev = bus.port1_req;
        end
        if (bus.port2_req !== p2_prev) begin
            q2.push_back({bus.port2_a, bus.port2_ds, bus.port2_d});
            p2_prev = bus.port2_req;
        end
        if (mon_en && bus.ioctl_wait !== ((bus.port1_req !== bus.port1_ack) || (bus.port2_req !== bus.port2_ack)))
            wait_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [24:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (bus.ioctl_wait === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL send_timeout: ioctl_wait=%b exp=0 within 200 cycles", bus.ioctl_wait);
        end
        bus.ioctl_addr = a;
        bus.ioctl_dout = b;
        bus.ioctl_wr   = 1'b1;
        @(negedge clk);
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (!(bus.ioctl_wait === 1'b0 && bus.port1_req === bus.port1_ack &&
                 bus.port2_req === bus.port2_ack) && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL quiet_timeout: wait=%b req1=%b ack1=%b exp idle", bus.ioctl_wait, bus.port1_req, bus.port1_ack);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_loaded();
        int n = 0;
        while (bus.rom_loaded !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.rom_loaded !== 1'b1) begin
            bad++;
            $display("FAIL rom_loaded_rise: got=%b exp=1", bus.rom_loaded);
        end
    endtask

    task automatic test_reset();
        total++; if (bus.ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait: got=%b exp=0", bus.ioctl_wait); end
        total++; if (bus.rom_loaded !== 1'b0) begin bad++; $display("FAIL rst_loaded: got=%b exp=0", bus.rom_loaded); end
        total++; if (bus.port1_req !== 1'b0) begin bad++; $display("FAIL rst_req1: got=%b exp=0", bus.port1_req); end
        total++; if (bus.port2_req !== 1'b0) begin bad++; $display("FAIL rst_req2: got=%b exp=0", bus.port2_req); end
        total++; if ({bus.port1_a, bus.port1_ds, bus.port1_d} !== 41'd0) begin bad++;
            $display("FAIL rst_port1: got=%h exp=0", {bus.port1_a, bus.port1_ds, bus.port1_d}); end
        total++; if ({bus.port1_we, bus.port2_we} !== 2'b11) begin bad++;
            $display("FAIL rst_we: got=%b exp=11", {bus.port1_we, bus.port2_we}); end
    endtask

    task automatic test_word_pairs();
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        q1.delete(); q2.delete(); wait_err = 0; mon_en = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(25'(i), bytes[i]);
        wait_quiet();
        mon_en = 1'b0;
        total++; if (q1.size() != 2) begin bad++; $display("FAIL pairs_count: got=%0d exp=2", q1.size()); end
        total++; if (q2.size() != 0) begin bad++; $display("FAIL pairs_p2: got=%0d exp=0", q2.size()); end
        if (q1.size() >= 2) begin
            total++; if (q1[0] !== {23'd0, 2'b11, 16'h2211}) begin bad++; $display("FAIL pairs_w0: got=%h exp=%h", q1[0], {23'd0, 2'b11, 16'h2211}); end
            total++; if (q1[1] !== {23'd1, 2'b11, 16'h4433}) begin bad++; $display("FAIL pairs_w1: got=%h exp=%h", q1[1], {23'd1, 2'b11, 16'h4433}); end
        end
        total++; if (wait_err != 0) begin bad++; $display("FAIL pairs_wait: got=%0d bad cycles exp=0", wait_err); end
    endtask

    task automatic test_port2();
        logic r1;
        q1.delete(); q2.delete(); wait_err = 0; mon_en = 1'b1;
        r1 = bus.port1_req;
        send_byte(25'h0100000, 8'h55);
        send_byte(25'h0100001, 8'h66);
        wait_quiet();
        mon_en = 1'b0;
        total++; if (bus.port1_req !== r1) begin bad++; $display("FAIL p2_req1: got=%b exp=%b", bus.port1_req, r1); end
        total++; if (q2.size() != 1) begin bad++; $display("FAIL p2_count: got=%0d exp=1", q2.size()); end
        if (q2.size() >= 1) begin
            total++; if (q2[0] !== {23'd0, 2'b11, 16'h6655}) begin bad++; $display("FAIL p2_word: got=%h exp=%h", q2[0], {23'd0, 2'b11, 16'h6655}); end
        end
        total++; if (wait_err != 0) begin bad++; $display("FAIL p2_wait: got=%0d bad cycles exp=0", wait_err); end
    endtask

    task automatic test_split();
        logic [40:0] e;
        q1.delete(); q2.delete();
        send_byte(25'd4, 8'h77);
        send_byte(25'd10, 8'h88);
        total++; if (bus.ioctl_wait !== 1'b1) begin bad++; $display("FAIL split_wait: got=%b exp=1", bus.ioctl_wait); end
        wait_quiet();
        repeat (10) @(negedge clk);
        total++; if (q1.size() != 1) begin bad++; $display("FAIL split_count: got=%0d exp=1", q1.size()); end
        total++; if (bus.ioctl_wait !== 1'b0) begin bad++; $display("FAIL split_half_wait: got=%b exp=0", bus.ioctl_wait); end
        if (q1.size() >= 1) begin
            e = q1[0];
            total++; if (e[40:18] !== 23'd2) begin bad++; $display("FAIL split_a: got=%0d exp=2", e[40:18]); end
            total++; if (e[17:16] !== 2'b01) begin bad++; $display("FAIL split_ds: got=%b exp=01", e[17:16]); end
            total++; if (e[7:0] !== 8'h77) begin bad++; $display("FAIL split_lo: got=%h exp=77", e[7:0]); end
        end
        send_byte(25'd11, 8'h99);
        wait_quiet();
        total++; if (q1.size() != 2) begin bad++; $display("FAIL split_count2: got=%0d exp=2", q1.size()); end
        if (q1.size() >= 2) begin
            total++; if (q1[1] !== {23'd5, 2'b11, 16'h9988}) begin bad++; $display("FAIL split_w5: got=%h exp=%h", q1[1], {23'd5, 2'b11, 16'h9988}); end
        end
    endtask

    task automatic test_odd_length();
        logic [40:0] e;
        q1.delete(); q2.delete();
        send_byte(25'd0, 8'hA1);
        send_byte(25'd1, 8'hA2);
        send_byte(25'd2, 8'hA3);
        wait_quiet();
        total++; if (bus.rom_loaded !== 1'b0) begin bad++; $display("FAIL odd_loaded_early: got=%b exp=0", bus.rom_loaded); end
        bus.ioctl_download = 1'b0;
        @(negedge clk);
        total++; if (bus.rom_loaded !== 1'b0) begin bad++; $display("FAIL odd_loaded_flush: got=%b exp=0", bus.rom_loaded); end
        wait_loaded();
        total++; if (q1.size() != 2) begin bad++; $display("FAIL odd_count: got=%0d exp=2", q1.size()); end
        if (q1.size() >= 2) begin
            total++; if (q1[0] !== {23'd0, 2'b11, 16'hA2A1}) begin bad++; $display("FAIL odd_w0: got=%h exp=%h", q1[0], {23'd0, 2'b11, 16'hA2A1}); end
            e = q1[1];
            total++; if ({e[40:18], e[17:16], e[7:0]} !== {23'd1, 2'b01, 8'hA3}) begin bad++;
                $display("FAIL odd_tail: got a=%0d ds=%b lo=%h exp a=1 ds=01 lo=a3", e[40:18], e[17:16], e[7:0]); end
        end
        bus.ioctl_index = 8'd0;
        bus.ioctl_download = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.rom_loaded !== 1'b0) begin bad++; $display("FAIL odd_reload_clear: got=%b exp=0", bus.rom_loaded); end
        bus.ioctl_download = 1'b0;
        wait_loaded();
    endtask

    task automatic test_index_mismatch();
        logic r1, r2;
        q1.delete(); q2.delete();
        r1 = bus.port1_req; r2 = bus.port2_req;
        bus.ioctl_index = 8'h05;
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte(25'(i), 8'hE0 + 8'(i));
            total++; if (bus.ioctl_wait !== 1'b0) begin bad++; $display("FAIL idx_wait: got=%b exp=0", bus.ioctl_wait); end
        end
        repeat (8) @(negedge clk);
        total++; if ({bus.port1_req, bus.port2_req} !== {r1, r2}) begin bad++;
            $display("FAIL idx_req: got=%b exp=%b", {bus.port1_req, bus.port2_req}, {r1, r2}); end
        total++; if (bus.rom_loaded !== 1'b1) begin bad++; $display("FAIL idx_loaded: got=%b exp=1", bus.rom_loaded); end
        bus.ioctl_download = 1'b0;
        bus.ioctl_index = 8'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus.ioctl_download = 1'b1;
        @(negedge clk);
        ack_en = 1'b0;
        send_byte(25'd0, 8'hC1);
        send_byte(25'd1, 8'hC2);
        total++; if (bus.port1_req === bus.port1_ack) begin bad++; $display("FAIL mid_outstanding: req=%b ack=%b exp differ", bus.port1_req, bus.port1_ack); end
        total++; if (bus.ioctl_wait !== 1'b1) begin bad++; $display("FAIL mid_wait_pre: got=%b exp=1", bus.ioctl_wait); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.port1_req !== bus.port1_ack) begin bad++; $display("FAIL mid_req_reset: req=%b exp=%b", bus.port1_req, bus.port1_ack); end
        total++; if (bus.ioctl_wait !== 1'b0) begin bad++; $display("FAIL mid_wait_reset: got=%b exp=0", bus.ioctl_wait); end
        total++; if ({bus.port1_a, bus.port1_ds, bus.port1_d} !== 41'd0) begin bad++;
            $display("FAIL mid_port1_reset: got=%h exp=0", {bus.port1_a, bus.port1_ds, bus.port1_d}); end
        reset = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        q1.delete(); q2.delete();
        send_byte(25'd6, 8'hD1);
        send_byte(25'd7, 8'hD2);
        wait_quiet();
        total++; if (q1.size() != 1) begin bad++; $display("FAIL mid_count: got=%0d exp=1", q1.size()); end
        if (q1.size() >= 1) begin
            total++; if (q1[0] !== {23'd3, 2'b11, 16'hD2D1}) begin bad++; $display("FAIL mid_word: got=%h exp=%h", q1[0], {23'd3, 2'b11, 16'hD2D1}); end
        end
        bus.ioctl_download = 1'b0;
        wait_loaded();
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        bus.ioctl_download = 1'b1;
        test_word_pairs();
        test_port2();
        test_split();
        test_odd_length();
        test_index_mismatch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
